// File: rtl/btn_bank_debounce.sv
// N-channel push-button front end: synchroniser, debounce, press/release strobes, last-pressed register.
// Define BTN_AUTOREPEAT_EN to build the hold-to-repeat strike logic; otherwise hit == press.
module btn_bank_debounce #(
  parameter int N_BTN        = 4,
  parameter int DEB_CYCLES   = 1_000_000,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [N_BTN-1:0]                             btn,
  output logic [N_BTN-1:0]                             state,
  output logic [N_BTN-1:0]                             press,
  output logic [N_BTN-1:0]                             released,
  output logic [N_BTN-1:0]                             hit,
  output logic [N_BTN-1:0]                             last_onehot,
  output logic [((N_BTN > 1) ? $clog2(N_BTN) : 1)-1:0] last_idx,
  output logic                                         last_valid
);

  localparam int IDX_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;
  localparam int DEB_W = $clog2(DEB_CYCLES);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [N_BTN-1:0] sync_p0;
  logic [N_BTN-1:0] s_p1;
  logic [DEB_W-1:0] deb_cnt [N_BTN];
  logic [N_BTN-1:0] differ;
  logic [N_BTN-1:0] fire;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] fall;

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_BTN-1:0] v);
    lowest_idx = '0;
    for (int i = N_BTN - 1; i >= 0; i--)
      if (v[i]) lowest_idx = IDX_W'(i);
  endfunction

  // Stage p1 -> debounce decision: fire means the mismatch has lasted DEB_CYCLES cycles
  always_comb begin
    differ = '0;
    fire   = '0;
    for (int i = 0; i < N_BTN; i++) begin
      differ[i] = s_p1[i] ^ state[i];
      fire[i]   = differ[i] && (deb_cnt[i] == DEB_LAST);
    end
    rise = fire & s_p1;
    fall = fire & ~s_p1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0  <= '0;
      s_p1     <= '0;
      state    <= '0;
      press    <= '0;
      released <= '0;
      for (int i = 0; i < N_BTN; i++) deb_cnt[i] <= '0;
    end else begin
      sync_p0  <= btn;
      s_p1     <= sync_p0;
      state    <= state ^ fire;
      press    <= rise;
      released <= fall;
      for (int i = 0; i < N_BTN; i++)
        deb_cnt[i] <= (differ[i] && !fire[i]) ? deb_cnt[i] + DEB_W'(1) : '0;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX);
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {IDLE, DELAY, RPT} rpt_state_t;
  rpt_state_t       rpt_st  [N_BTN];
  logic [RPT_W-1:0] rpt_cnt [N_BTN];

  // Repeat FSM reacts to the same-edge rise/fall so a release cycle never carries a strike
  always_ff @(posedge clk) begin
    if (rst) begin
      hit <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        rpt_st[i]  <= IDLE;
        rpt_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        hit[i] <= rise[i];
        if (fall[i] || (!state[i] && !rise[i])) begin
          rpt_st[i]  <= IDLE;
          rpt_cnt[i] <= '0;
        end else if (rise[i]) begin
          rpt_st[i]  <= DELAY;
          rpt_cnt[i] <= '0;
        end else begin
          case (rpt_st[i])
            DELAY: begin
              if (rpt_cnt[i] == DELAY_LAST) begin
                rpt_st[i]  <= RPT;
                rpt_cnt[i] <= '0;
                hit[i]     <= 1'b1;
              end else begin
                rpt_cnt[i] <= rpt_cnt[i] + RPT_W'(1);
              end
            end
            RPT: begin
              if (rpt_cnt[i] == RATE_LAST) begin
                rpt_cnt[i] <= '0;
                hit[i]     <= 1'b1;
              end else begin
                rpt_cnt[i] <= rpt_cnt[i] + RPT_W'(1);
              end
            end
            default: begin
              rpt_st[i]  <= IDLE;
              rpt_cnt[i] <= '0;
            end
          endcase
        end
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) hit <= '0;
    else     hit <= rise;
  end
`endif

  // Stage p2: last-pressed register follows the registered press strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      last_onehot <= '0;
      last_idx    <= '0;
      last_valid  <= 1'b0;
    end else if (press != '0) begin
      last_onehot <= press & (~press + N_BTN'(1));
      last_idx    <= lowest_idx(press);
      last_valid  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_btn_bank_debounce.sv
// Bench for btn_bank_debounce: directed scenarios plus random stimulus against a window-based reference model.
module tb_btn_bank_debounce;

  localparam int N   = 4;
  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RR  = 5;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit RPT_ON = 1'b1;
`else
  localparam bit RPT_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn = '0;
  logic [N-1:0] state, press, released, hit, last_onehot;
  logic [1:0]   last_idx;
  logic         last_valid;

  int n_checks = 0;
  int n_fail   = 0;

  btn_bank_debounce #(
    .N_BTN(N), .DEB_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn), .state(state), .press(press),
    .released(released), .hit(hit), .last_onehot(last_onehot),
    .last_idx(last_idx), .last_valid(last_valid)
  );

  always #5 clk = ~clk;

  // Reference model: a level is accepted once the last DEB synchronised samples all differ from it
  logic [15:0]  hist [N];
  int           age  [N];
  logic [N-1:0] m_state = '0, m_press = '0, m_rel = '0, m_hit = '0, m_last = '0;
  logic [1:0]   m_idx = '0;
  logic         m_valid = 1'b0;

  task automatic model_step();
    if (rst) begin
      for (int ch = 0; ch < N; ch++) begin
        hist[ch] = '0;
        age[ch]  = 0;
      end
      m_state = '0; m_press = '0; m_rel = '0; m_hit = '0;
      m_last = '0; m_idx = '0; m_valid = 1'b0;
    end else begin
      if (m_press != '0) begin
        m_valid = 1'b1;
        for (int i = N - 1; i >= 0; i--)
          if (m_press[i]) begin
            m_last = '0;
            m_last[i] = 1'b1;
            m_idx = 2'(i);
          end
      end
      for (int ch = 0; ch < N; ch++) begin
        logic win;
        hist[ch] = {hist[ch][14:0], btn[ch]};
        win = 1'b1;
        for (int k = 2; k <= DEB + 1; k++)
          if (hist[ch][k] == m_state[ch]) win = 1'b0;
        m_press[ch] = win & ~m_state[ch];
        m_rel[ch]   = win & m_state[ch];
        if (win) m_state[ch] = ~m_state[ch];
        if (m_press[ch]) age[ch] = 0;
        else if (m_state[ch]) age[ch]++;
        m_hit[ch] = m_press[ch];
        if (RPT_ON && m_state[ch] && !m_press[ch] && age[ch] >= RD && ((age[ch] - RD) % RR) == 0)
          m_hit[ch] = 1'b1;
      end
    end
  endtask

  function automatic logic [22:0] model_vec();
    return {m_state, m_press, m_rel, m_hit, m_last, m_idx, m_valid};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn = '0;
    tick();
    tick();
    n_checks++;
    if ({state, press, released, hit, last_onehot, last_idx, last_valid} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h want 0", {state, press, released, hit, last_onehot, last_idx, last_valid});
    end
    rst = 1'b0;
  endtask

  task automatic test_press_hold();
    int press_at = -1;
    int presses = 0;
    btn[2] = 1'b1;
    for (int t = 1; t <= 30; t++) begin
      tick();
      n_checks++;
      if ({state, press, released, hit, last_onehot, last_idx, last_valid} !== model_vec()) begin
        n_fail++;
        $display("FAIL press_hold t=%0d got %h want %h", t, {state, press, released, hit, last_onehot, last_idx, last_valid}, model_vec());
      end
      if (press[2]) begin
        presses++;
        if (press_at < 0) press_at = t;
      end
      if (t == press_at + 1 && press_at > 0) begin
        n_checks++;
        if (last_onehot !== 4'b0100 || last_idx !== 2'd2 || last_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL press_hold_last got %b/%0d/%b want 0100/2/1", last_onehot, last_idx, last_valid);
        end
      end
    end
    n_checks++;
    if (press_at !== 6 || presses !== 1 || state[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL press_hold_timing got at=%0d n=%0d st=%b want at=6 n=1 st=1", press_at, presses, state[2]);
    end
  endtask

  task automatic test_release();
    int rel_at = -1;
    int rels = 0;
    btn[2] = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      n_checks++;
      if ({state, press, released, hit, last_onehot, last_idx, last_valid} !== model_vec()) begin
        n_fail++;
        $display("FAIL release t=%0d got %h want %h", t, {state, press, released, hit, last_onehot, last_idx, last_valid}, model_vec());
      end
      if (released[2]) begin
        rels++;
        if (rel_at < 0) rel_at = t;
      end
    end
    n_checks++;
    if (rel_at !== 6 || rels !== 1 || state[2] !== 1'b0 || last_onehot !== 4'b0100) begin
      n_fail++;
      $display("FAIL release_timing got at=%0d n=%0d st=%b last=%b want at=6 n=1 st=0 last=0100", rel_at, rels, state[2], last_onehot);
    end
  endtask

  task automatic test_bounce();
    int press_at = -1;
    int early = 0;
    for (int c = 0; c < 12; c++) begin
      btn[0] = ((c / 2) % 2 == 0);
      tick();
      if (state[0] || press[0]) early++;
      n_checks++;
      if ({state, press, released, hit, last_onehot, last_idx, last_valid} !== model_vec()) begin
        n_fail++;
        $display("FAIL bounce c=%0d got %h want %h", c, {state, press, released, hit, last_onehot, last_idx, last_valid}, model_vec());
      end
    end
    btn[0] = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (press[0] && press_at < 0) press_at = t;
      n_checks++;
      if ({state, press, released, hit, last_onehot, last_idx, last_valid} !== model_vec()) begin
        n_fail++;
        $display("FAIL bounce_settle t=%0d got %h want %h", t, {state, press, released, hit, last_onehot, last_idx, last_valid}, model_vec());
      end
    end
    n_checks++;
    if (early !== 0 || press_at !== 6) begin
      n_fail++;
      $display("FAIL bounce_timing got early=%0d at=%0d want early=0 at=6", early, press_at);
    end
  endtask

  task automatic test_simultaneous();
    logic [N-1:0] seen = '0;
    btn[1] = 1'b1;
    btn[3] = 1'b1;
    for (int t = 1; t <= 9; t++) begin
      tick();
      if (t == 6) seen = press;
      n_checks++;
      if ({state, press, released, hit, last_onehot, last_idx, last_valid} !== model_vec()) begin
        n_fail++;
        $display("FAIL simultaneous t=%0d got %h want %h", t, {state, press, released, hit, last_onehot, last_idx, last_valid}, model_vec());
      end
    end
    n_checks++;
    if (seen !== 4'b1010 || last_onehot !== 4'b0010 || last_idx !== 2'd1) begin
      n_fail++;
      $display("FAIL simultaneous_prio got press=%b last=%b idx=%0d want 1010/0010/1", seen, last_onehot, last_idx);
    end
  endtask

  task automatic test_repeat();
    int hits = 0;
    int first_at = -1;
    int second_at = -1;
    int rel_hit = 0;
    btn = '0;
    for (int t = 0; t < 12; t++) tick();
    btn[1] = 1'b1;
    for (int t = 1; t <= 75; t++) begin
      if (t == 61) btn[1] = 1'b0;
      tick();
      if (hit[1]) begin
        hits++;
        if (first_at < 0) first_at = t;
        else if (second_at < 0) second_at = t;
      end
      if (hit[1] && released[1]) rel_hit++;
      n_checks++;
      if ({state, press, released, hit, last_onehot, last_idx, last_valid} !== model_vec()) begin
        n_fail++;
        $display("FAIL repeat t=%0d got %h want %h", t, {state, press, released, hit, last_onehot, last_idx, last_valid}, model_vec());
      end
    end
    // press at 6, strikes at 26,31..61; the strike due at 66 coincides with the release
    n_checks++;
    if (hits !== (RPT_ON ? 9 : 1) || first_at !== 6 || rel_hit !== 0 ||
        second_at !== (RPT_ON ? 26 : -1)) begin
      n_fail++;
      $display("FAIL repeat_count got n=%0d first=%0d second=%0d relhit=%0d want n=%0d first=6 second=%0d relhit=0",
               hits, first_at, second_at, rel_hit, RPT_ON ? 9 : 1, RPT_ON ? 26 : -1);
    end
  endtask

  task automatic test_reset_held();
    int press_at = -1;
    btn = 4'b1000;
    for (int t = 1; t <= 8; t++) tick();
    n_checks++;
    if (state[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_held_pre got state3=%b want 1", state[3]);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({state, press, released, hit, last_onehot, last_idx, last_valid} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_held_clear got %h want 0", {state, press, released, hit, last_onehot, last_idx, last_valid});
    end
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (press[3] && press_at < 0) press_at = t;
      n_checks++;
      if (released !== 4'b0000 || {state, press, released, hit, last_onehot, last_idx, last_valid} !== model_vec()) begin
        n_fail++;
        $display("FAIL reset_held t=%0d got %h want %h", t, {state, press, released, hit, last_onehot, last_idx, last_valid}, model_vec());
      end
    end
    n_checks++;
    if (press_at !== 6) begin
      n_fail++;
      $display("FAIL reset_held_repress got at=%0d want 6", press_at);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 1500; t++) begin
      for (int ch = 0; ch < N; ch++)
        if ($urandom_range(9) == 0) btn[ch] = ~btn[ch];
      rst = ($urandom_range(299) == 0);
      tick();
      n_checks++;
      if ({state, press, released, hit, last_onehot, last_idx, last_valid} !== model_vec()) begin
        n_fail++;
        $display("FAIL random t=%0d got %h want %h", t, {state, press, released, hit, last_onehot, last_idx, last_valid}, model_vec());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_press_hold();
    test_release();
    test_bounce();
    test_simultaneous();
    test_repeat();
    test_reset_held();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
